// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// One BCD-to-7-segment decoder is shared by all digits. This block does four things:
//   - It presents one BCD nibble at a time to that shared decoder.
//   - It drives the matching one-hot digit enable.
//   - It steps through the digits, holding each one for REFRESH_DIV clock cycles.
//   - It double-buffers the display value, so a new value only appears at a
//     frame boundary. A frame can therefore never show half old data and half new data.
// It also blanks leading zeros and flags committed nibbles that are not valid BCD.
//
// Parameters
//   NUM_DIGITS   number of scanned digits (>= 2)
//   REFRESH_DIV  clk cycles each digit stays active (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           scan enable; 0 = display dark, scan position frozen
//   load_valid   new display value offered on load_data
//   load_ready   block can accept load_data (no load pending)
//   load_data    BCD nibbles, [3:0] = digit 0 (least significant digit)
//   lzb_en       leading-zero blanking enable
//   err_clr      clears bcd_err (a simultaneous new error wins)
//   digit_bcd    nibble for the shared decoder inputs {a,b,c,d}
//   digit_blank  1 = gate decoder segments off for the current digit
//   digit_an     one-hot digit enable, active-high
//   frame_done   one-cycle pulse after the digit index wraps to 0
//   bcd_err      sticky flag: a committed nibble was greater than 9
//
// Every output is decoded from registered state only; no input reaches an
// output combinationally. The scan enable and the blanking enable are
// therefore registered first. The scan position advances only while the
// registered enable is high. As a result, each digit is visible on digit_an
// for exactly REFRESH_DIV cycles, and the frame_done pulse coincides with
// the first cycle of digit 0.
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    lzb_en,
  input  logic                    err_clr,
  output logic [3:0]              digit_bcd,
  output logic                    digit_blank,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic                    frame_done,
  output logic                    bcd_err
);

  localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [TICK_W-1:0]       tick_reg,      tick_next;
  logic [IDX_W-1:0]        idx_reg,       idx_next;
  logic [4*NUM_DIGITS-1:0] shadow_reg,    shadow_next;     // value on display
  logic [4*NUM_DIGITS-1:0] pend_data_reg, pend_data_next;  // accepted, not yet shown
  logic                    pend_reg,      pend_next;
  logic                    err_reg,       err_next;
  logic                    frame_done_reg, frame_done_next;
  logic                    scan_on_reg;                    // registered en
  logic                    lzb_reg;                        // registered lzb_en

  // -------------------------------------------------------------------------
  // Per-digit helpers
  // -------------------------------------------------------------------------
  logic [3:0]            shadow_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] pend_bad;     // pending nibble is not valid BCD
  logic [NUM_DIGITS-1:0] upper_zero;   // nibbles gi..NUM_DIGITS-1 are all zero

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign shadow_nib[gi] = shadow_reg[4*gi +: 4];
      assign pend_bad[gi]   = (pend_data_reg[4*gi +: 4] > 4'd9);
      // Each digit takes a constant slice of the upper nibbles. This avoids a
      // bit-to-bit dependency chain inside one vector.
      assign upper_zero[gi] = ~|shadow_reg[4*NUM_DIGITS-1 : 4*gi];
      assign digit_an[gi]   = scan_on_reg && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic tick_end;
  logic frame_end;
  logic commit;
  logic accept;

  always_comb begin
    tick_end  = (tick_reg == TICK_LAST);
    frame_end = tick_end && (idx_reg == IDX_LAST);

    // While scanning, a pending value only moves to the display on the
    // frame-boundary edge. While dark, nothing can tear, so it moves at once.
    commit = pend_reg && (!scan_on_reg || frame_end);

    // Acceptance depends only on pend_reg. A load offered on the boundary
    // edge itself therefore waits for the following boundary.
    accept = load_valid && !pend_reg;

    tick_next       = tick_reg;
    idx_next        = idx_reg;
    shadow_next     = shadow_reg;
    pend_data_next  = pend_data_reg;
    pend_next       = pend_reg;
    err_next        = err_reg;
    frame_done_next = 1'b0;

    if (scan_on_reg) begin
      if (tick_end) begin
        tick_next = '0;
        idx_next  = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        tick_next = tick_reg + 1'b1;
      end
      frame_done_next = frame_end;
    end

    // commit and accept are mutually exclusive: commit needs pend_reg=1,
    // and accept needs pend_reg=0.
    if (commit) begin
      shadow_next = pend_data_reg;
      pend_next   = 1'b0;
    end else if (accept) begin
      pend_data_next = load_data;
      pend_next      = 1'b1;
    end

    // A new error outranks a clear on the same edge.
    if (commit && |pend_bad) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_reg       <= '0;
      idx_reg        <= '0;
      shadow_reg     <= '0;
      pend_data_reg  <= '0;
      pend_reg       <= 1'b0;
      err_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
      scan_on_reg    <= 1'b0;
      lzb_reg        <= 1'b0;
    end else begin
      tick_reg       <= tick_next;
      idx_reg        <= idx_next;
      shadow_reg     <= shadow_next;
      pend_data_reg  <= pend_data_next;
      pend_reg       <= pend_next;
      err_reg        <= err_next;
      frame_done_reg <= frame_done_next;
      scan_on_reg    <= en;
      lzb_reg        <= lzb_en;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [3:0] cur_nib;
  logic       lzb_blank;

  always_comb begin
    cur_nib = shadow_nib[idx_reg];
    // Digit 0 always shows, so that a value of zero still displays "0".
    lzb_blank = lzb_reg && (idx_reg != '0) && upper_zero[idx_reg];
  end

  assign digit_bcd   = cur_nib;
  assign digit_blank = (cur_nib > 4'd9) || lzb_blank;
  assign load_ready  = !pend_reg;
  assign frame_done  = frame_done_reg;
  assign bcd_err     = err_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Testbench for seg7_scan_ctrl with NUM_DIGITS=4 and REFRESH_DIV=4.
// The reference model describes the display at a high level:
//   - the scan is a single frame position 0..15 that moves while the display is on;
//   - the visible digit is position/4;
//   - a pending value replaces the displayed one at the end of a frame.
// Inputs are driven on the falling edge. The model steps on the rising edge.
// Outputs are compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           load_valid;
  logic           load_ready;
  logic [4*N-1:0] load_data;
  logic           lzb_en;
  logic           err_clr;
  logic [3:0]     digit_bcd;
  logic           digit_blank;
  logic [N-1:0]   digit_an;
  logic           frame_done;
  logic           bcd_err;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .lzb_en      (lzb_en),
    .err_clr     (err_clr),
    .digit_bcd   (digit_bcd),
    .digit_blank (digit_blank),
    .digit_an    (digit_an),
    .frame_done  (frame_done),
    .bcd_err     (bcd_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int m_shadow [N];
  int m_buf    [N];
  int m_pos;
  bit m_on, m_pend, m_err, m_fd, m_lzb;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // One rising edge of the reference model, driven by the inputs as they are now.
  task automatic model_edge();
    bit last, commit, accept, bad;
    if (rst) begin
      foreach (m_shadow[j]) begin
        m_shadow[j] = 0;
        m_buf[j]    = 0;
      end
      m_pos = 0; m_on = 0; m_pend = 0; m_err = 0; m_fd = 0; m_lzb = 0;
      return;
    end
    last   = (m_pos == FRAME - 1);
    commit = m_pend && (!m_on || last);
    accept = load_valid && !m_pend;
    bad    = 0;
    foreach (m_buf[j]) if (m_buf[j] > 9) bad = 1;
    if (commit && bad) m_err = 1;
    else if (err_clr)  m_err = 0;
    m_fd = m_on && last;
    if (m_on) m_pos = (m_pos + 1) % FRAME;
    if (commit) begin
      foreach (m_buf[j]) m_shadow[j] = m_buf[j];
      m_pend = 0;
      $display("commit  value=%h%h%h%h err=%0d", m_buf[3], m_buf[2], m_buf[1], m_buf[0], m_err);
    end else if (accept) begin
      foreach (m_buf[j]) m_buf[j] = int'((load_data >> (4*j)) & 16'hF);
      m_pend = 1;
      $display("load    value=%h", load_data);
    end
    m_on  = en;
    m_lzb = lzb_en;
  endtask

  task automatic check_outputs();
    int  idx;
    bit  zeros;
    int  exp_an;
    idx   = m_pos / DIV;
    zeros = 1;
    for (int j = idx; j < N; j++) if (m_shadow[j] != 0) zeros = 0;
    exp_an = m_on ? (1 << idx) : 0;
    check_val("load_ready",  load_ready,  !m_pend);
    check_val("digit_an",    digit_an,    exp_an);
    check_val("digit_bcd",   digit_bcd,   m_shadow[idx]);
    check_val("digit_blank", digit_blank, (m_shadow[idx] > 9) || (m_lzb && idx != 0 && zeros));
    check_val("frame_done",  frame_done,  m_fd);
    check_val("bcd_err",     bcd_err,     m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic load_once(input logic [15:0] value);
    load_valid = 1; load_data = value;
    cycle();
    load_valid = 0;
  endtask

  function automatic logic [3:0] rand_nib();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4)  return 4'd0;
    if (r == 9) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(1, 9));
  endfunction

  initial begin
    int n;
    rst = 1; en = 0; load_valid = 0; load_data = '0; lzb_en = 0; err_clr = 0;
    cycle();
    cycle();

    // Frame timing after reset: the first digit_an=0001 cycle, then the
    // frame_done pulse 16 cycles later, still showing digit 0.
    rst = 0; en = 1;
    cycle();
    check_val("first_an", digit_an, 4'b0001);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      n++;
      if (frame_done) break;
    end
    check_val("fd_latency", n, FRAME);
    check_val("fd_an", digit_an, 4'b0001);

    // A mid-frame load is held back until the boundary, then shown with LZB.
    repeat (5) cycle();
    lzb_en = 1;
    load_once(16'h0123);
    repeat (2 * FRAME) cycle();

    // Leading-zero blanking for an all-zero value and a top-digit-only value,
    // each shown with blanking on and then off.
    load_once(16'h0000);
    repeat (FRAME + 4) cycle();
    lzb_en = 0;
    repeat (FRAME) cycle();
    load_once(16'h1000);
    repeat (FRAME) cycle();
    lzb_en = 1;
    repeat (FRAME + 4) cycle();

    // Invalid BCD sets the sticky error. err_clr clears it. An invalid commit
    // while err_clr is held still sets the error.
    load_once(16'h00A5);
    repeat (2 * FRAME) cycle();
    err_clr = 1; cycle(); err_clr = 0;
    repeat (3) cycle();
    load_once(16'h00B0);
    err_clr = 1;
    repeat (2 * FRAME) cycle();
    err_clr = 0;

    // Freeze the scan at digit 2, tick 1 for 10 cycles, then resume.
    for (int k = 0; k < 100 && !(m_on && m_pos == 2 * DIV + 1); k++) cycle();
    check_val("freeze_pos", m_pos, 2 * DIV + 1);
    en = 0;
    repeat (10) cycle();
    en = 1;
    repeat (2 * FRAME) cycle();

    // Reset while a load is pending on the last digit.
    for (int k = 0; k < 100 && (m_pos / DIV) != 3; k++) cycle();
    load_once(16'h4321);
    rst = 1; cycle(); rst = 0;
    check_val("rst_an", digit_an, 4'b0000);
    repeat (2) cycle();

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      rst        = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) lzb_en = ~lzb_en;
      err_clr    = ($urandom_range(0, 15) == 0);
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = {rand_nib(), rand_nib(), rand_nib(), rand_nib()};
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
